// File: rtl/conv_pkg.sv
// Shared types and defaults for the convolution beat scheduler.
package conv_pkg;

    localparam int DEF_WIDTH     = 32;
    localparam int DEF_INPUT_NUM = 4;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        OUTPUT
    } state_t;

    typedef logic [DEF_INPUT_NUM-1:0][DEF_WIDTH-1:0] lane_vec_t;

endpackage

// File: rtl/conv_valid_pipe.sv
// Valid-tag delay line that shadows beats through the reduction datapath.
module conv_valid_pipe #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic out
);

    logic [DEPTH-1:0] tags;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tags <= '0;
        end else begin
            tags[0] <= in;
            for (int i = 1; i < DEPTH; i++) begin
                tags[i] <= tags[i-1];
            end
        end
    end

    assign out = tags[DEPTH-1];

endmodule

// File: rtl/conv_sched.sv
// Issues operand beats to an external reduction datapath and accumulates its lane sums.
module conv_sched
    import conv_pkg::*;
#(
    parameter int INPUT_NUM = DEF_INPUT_NUM,
    parameter int WIDTH     = DEF_WIDTH,
    parameter int LEN_W     = 16,
    parameter int DP_LAT    = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [LEN_W-1:0]           len,
    output logic                       busy,
    output logic                       src_req,
    output logic [LEN_W-1:0]           src_addr,
    input  logic                       src_valid,
    input  logic [INPUT_NUM*WIDTH-1:0] src_data,
    output logic [INPUT_NUM*WIDTH-1:0] dp_in,
    input  logic [WIDTH-1:0]           dp_out,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [WIDTH-1:0]           res_data
);

    localparam logic [LEN_W-1:0] ONE = 1;

    state_t state, state_nxt;

    logic [LEN_W-1:0] len_r;
    logic [LEN_W-1:0] issued;
    logic [LEN_W-1:0] done;
    logic [WIDTH-1:0] acc;
    logic             accept;
    logic             last_accept;
    logic             tag_out;
    logic             last_done;

    assign src_req     = (state == ISSUE) && (issued < len_r);
    assign accept      = src_req && src_valid;
    assign last_accept = accept && (issued == len_r - ONE);
    assign last_done   = tag_out && (done == len_r - ONE);

    assign busy      = (state != IDLE);
    assign res_valid = (state == OUTPUT);
    assign res_data  = (state == OUTPUT) ? acc : '0;
    assign src_addr  = issued;

    // Tag enters with the accept edge and exits the cycle dp_out holds that beat's sum.
    conv_valid_pipe #(
        .DEPTH(DP_LAT + 1)
    ) u_valid_pipe (
        .clk(clk),
        .rst(rst),
        .in (accept),
        .out(tag_out)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (len == '0) ? OUTPUT : ISSUE;
                end
            end
            ISSUE: begin
                if (last_accept) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (last_done) begin
                    state_nxt = OUTPUT;
                end
            end
            OUTPUT: begin
                if (res_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_r  <= '0;
            issued <= '0;
            done   <= '0;
            acc    <= '0;
            dp_in  <= '0;
        end else begin
            dp_in <= accept ? src_data : '0;
            if (state == IDLE && start) begin
                len_r  <= len;
                issued <= '0;
                done   <= '0;
                acc    <= '0;
            end else begin
                if (accept) begin
                    issued <= issued + ONE;
                end
                if (tag_out) begin
                    acc  <= acc + dp_out;
                    done <= done + ONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_conv_sched.sv
// Randomized bench: buffer and datapath models plus a sum-of-lanes reference.
module tb_conv_sched;
    import conv_pkg::*;

    localparam int IN  = 4;
    localparam int W   = 32;
    localparam int LW  = 16;
    localparam int DPL = 1;
    localparam int TMO = 300;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic [LW-1:0]   len = '0;
    logic            busy;
    logic            src_req;
    logic [LW-1:0]   src_addr;
    logic            src_valid = 1'b0;
    logic [IN*W-1:0] src_data = '0;
    logic [IN*W-1:0] dp_in;
    logic [W-1:0]    dp_out;
    logic            res_valid;
    logic            res_ready = 1'b0;
    logic [W-1:0]    res_data;

    int checks = 0;
    int errors = 0;

    lane_vec_t mem [16];
    logic [W-1:0] dp_pipe [DPL];

    conv_sched #(
        .INPUT_NUM(IN),
        .WIDTH    (W),
        .LEN_W    (LW),
        .DP_LAT   (DPL)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .len      (len),
        .busy     (busy),
        .src_req  (src_req),
        .src_addr (src_addr),
        .src_valid(src_valid),
        .src_data (src_data),
        .dp_in    (dp_in),
        .dp_out   (dp_out),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .res_data (res_data)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] lane_sum(input logic [IN*W-1:0] v);
        logic [W-1:0] s = '0;
        for (int l = 0; l < IN; l++) s += v[l*W +: W];
        return s;
    endfunction

    // Datapath model is deliberately not reset: stale sums must be ignored by the DUT.
    always @(posedge clk) begin
        dp_pipe[0] <= lane_sum(dp_in);
        for (int i = 1; i < DPL; i++) dp_pipe[i] <= dp_pipe[i-1];
    end
    assign dp_out = dp_pipe[DPL-1];

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] ref_sum(input int n);
        logic [W-1:0] s = '0;
        for (int b = 0; b < n; b++) s += lane_sum(mem[b]);
        return s;
    endfunction

    // mode: 0 src_valid always high, 1 toggling, 2 random
    task automatic run_job(input int n, input int mode, input int hold,
                           input bit start_at_ack);
        logic [W-1:0] exp;
        int  cyc   = 0;
        int  reqs  = 0;
        bit  tog   = 1'b1;
        bit  bz_ok = 1'b1;
        exp = ref_sum(n);
        @(negedge clk);
        start = 1'b1;
        len   = LW'(n);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        while (!res_valid && cyc < TMO) begin
            if (src_req) reqs++;
            if (!busy) bz_ok = 1'b0;
            if (mode == 0) src_valid = 1'b1;
            else if (mode == 1) begin
                src_valid = tog;
                tog = !tog;
            end else src_valid = 1'($urandom_range(0, 1));
            if (int'(src_addr) < n) src_data = mem[src_addr[3:0]];
            else src_data = {$urandom(), $urandom(), $urandom(), $urandom()};
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
        src_valid = 1'b0;
        check("timeout", 64'(cyc < TMO), 64'd1);
        check("busy_run", 64'(bz_ok), 64'd1);
        if (mode == 0) check("latency", 64'(cyc), 64'(n == 0 ? 0 : n + DPL + 1));
        if (n == 0) check("no_req", 64'(reqs), 64'd0);
        check("res_data", 64'(res_data), 64'(exp));
        for (int k = 0; k < hold; k++) begin
            @(posedge clk);
            @(negedge clk);
            check("hold_valid", 64'(res_valid), 64'd1);
            check("hold_data", 64'(res_data), 64'(exp));
            check("hold_busy", 64'(busy), 64'd1);
        end
        res_ready = 1'b1;
        start     = start_at_ack;
        len       = LW'(3);
        @(posedge clk);
        @(negedge clk);
        res_ready = 1'b0;
        start     = 1'b0;
        check("ack_busy", 64'(busy), 64'd0);
        check("ack_valid", 64'(res_valid), 64'd0);
        if (start_at_ack) begin
            @(posedge clk);
            @(negedge clk);
            check("ack_nostart", 64'(busy), 64'd0);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_req"}, 64'(src_req), 64'd0);
        check({tag, "_addr"}, 64'(src_addr), 64'd0);
        check({tag, "_dpin"}, 64'(dp_in != '0), 64'd0);
        check({tag, "_rv"}, 64'(res_valid), 64'd0);
        check({tag, "_rd"}, 64'(res_data), 64'd0);
    endtask

    initial begin
        #12;
        check_reset_state("rst0");
        @(negedge clk);
        rst = 1'b0;

        mem[0] = {32'd4, 32'd3, 32'd2, 32'd1};
        mem[1] = {32'd0, 32'd0, 32'd0, 32'd4};
        run_job(2, 0, 0, 1'b0);

        mem[0] = {4{32'hFFFF_FFFF}};
        mem[1] = {4{32'hFFFF_FFFF}};
        run_job(2, 0, 0, 1'b0);

        run_job(0, 0, 0, 1'b1);

        for (int b = 0; b < 3; b++) mem[b] = {$urandom(), $urandom(), $urandom(), $urandom()};
        run_job(3, 1, 5, 1'b0);

        for (int b = 0; b < 4; b++) mem[b] = {4{32'h0100_0000}};
        @(negedge clk);
        start = 1'b1;
        len   = LW'(4);
        src_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        src_data = mem[0];
        @(posedge clk);
        @(negedge clk);
        src_data = mem[1];
        @(posedge clk);
        #1 check("pre_rst_busy", 64'(busy), 64'd1);
        #1 rst = 1'b1;
        #1 check_reset_state("rst_mid");
        src_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        mem[0] = {32'd1, 32'd1, 32'd1, 32'd1};
        run_job(1, 0, 0, 1'b0);

        for (int j = 0; j < 30; j++) begin
            int n = $urandom_range(0, 8);
            for (int b = 0; b < 16; b++) mem[b] = {$urandom(), $urandom(), $urandom(), $urandom()};
            run_job(n, $urandom_range(0, 2), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
